seq_divider: RTL and testbench

- Iterative signed divider. It is the inverse of the team's combinational N x N array multiplier.
- Divides a 2N-bit two's-complement dividend by an N-bit divisor. Produces an N-bit quotient and an N-bit remainder using restoring division, one quotient bit per clock.
- Start/done handshake. Sits beside the multiplier in the arithmetic datapath and shares the ripple-adder primitive.

---
 rtl/div_pkg.sv | 23 ++
 rtl/N_ripple_adder.sv | 21 ++
 rtl/seq_divider.sv | 178 +++++++++++++++++
 tb/tb_seq_divider.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    // Controller states, in the order a normal division walks through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        CALC  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Default operand width.
    localparam int DIV_N = 8;

    // Bits needed to count quotient bits 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/N_ripple_adder.sv
// Ripple-carry adder primitive shared by the arithmetic datapath.
// sum = a + b + carry_in, truncated to W bits.
module N_ripple_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic [W-1:0] sum
);

    logic [W:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one
// quotient bit per clock, start/done handshake.
// Handshake: start is sampled only in IDLE (busy=0); busy is high from the
// cycle after an accepted start until done; done pulses for one cycle and
// quotient/remainder/overflow/div_by_zero are valid from that cycle and held.
// Build option: define DIV_SIGNED_EN for two's-complement operands and
// results; without it operands and results are unsigned.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t          state;
    logic [N-1:0]    hi;        // dividend magnitude, upper half
    logic [N-1:0]    lo;        // dividend magnitude, lower half (shifted out MSB first)
    logic [N-1:0]    dvs;       // divisor magnitude
    logic [N-1:0]    rem;       // partial remainder
    logic [N-1:0]    quo;       // magnitude quotient
    logic [CW-1:0]   cnt;
`ifdef DIV_SIGNED_EN
    logic            neg_dd;
    logic            neg_ds;
    localparam logic [N-1:0] Q_MIN_MAG = {1'b1, {(N-1){1'b0}}};
`endif

    logic [2*N-1:0]  dd_mag;
    logic [N-1:0]    ds_mag;
    logic [N:0]      shifted;
    logic [N:0]      trial_b;
    logic [N:0]      diff;
    logic            fits;
    logic [N-1:0]    q_fix;
    logic [N-1:0]    r_fix;
    logic            ovf_fix;

    // Trial subtraction on N+1 bits: shifted - dvs as shifted + ~dvs + 1.
    assign shifted = {rem, lo[N-1]};
    assign trial_b = ~{1'b0, dvs};
    assign fits    = ~diff[N];

    N_ripple_adder #(.W(N + 1)) u_trial (
        .a        (shifted),
        .b        (trial_b),
        .carry_in (1'b1),
        .sum      (diff)
    );

    // Operand magnitudes; the 2N-bit magnitude is unsigned so the most
    // negative dividend is representable.
    always_comb begin
        dd_mag = dividend;
        ds_mag = divisor;
`ifdef DIV_SIGNED_EN
        if (dividend[2*N-1]) dd_mag = -dividend;
        if (divisor[N-1])    ds_mag = -divisor;
`endif
    end

    // Sign fix-up and final range check of the magnitude quotient.
    always_comb begin
        q_fix   = quo;
        r_fix   = rem;
        ovf_fix = 1'b0;
`ifdef DIV_SIGNED_EN
        if (neg_dd ^ neg_ds) begin
            q_fix   = -quo;
            ovf_fix = (quo > Q_MIN_MAG);
        end else begin
            ovf_fix = quo[N-1];
        end
        if (neg_dd) r_fix = -rem;
        if (ovf_fix) begin
            q_fix = '0;
            r_fix = '0;
        end
`endif
    end

    // Controller and datapath registers with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hi          <= '0;
            lo          <= '0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
`ifdef DIV_SIGNED_EN
            neg_dd      <= 1'b0;
            neg_ds      <= 1'b0;
`endif
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        {hi, lo}    <= dd_mag;
                        dvs         <= ds_mag;
`ifdef DIV_SIGNED_EN
                        neg_dd      <= dividend[2*N-1];
                        neg_ds      <= divisor[N-1];
`endif
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (dvs == '0) begin
                        div_by_zero <= 1'b1;
                        quotient    <= '0;
                        remainder   <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else if (hi >= dvs) begin
                        overflow    <= 1'b1;
                        quotient    <= '0;
                        remainder   <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rem   <= hi;
                        quo   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= fits ? diff[N-1:0] : shifted[N-1:0];
                    quo <= {quo[N-2:0], fits};
                    lo  <= {lo[N-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) state <= FIX;
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    overflow  <= ovf_fix;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=8). Expected values are hand-computed;
// the DIV_SIGNED_EN build selects the signed vector set.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        overflow;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider #(.N(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One division. poke>0 pulses start with other operands in that cycle
    // (counted from the edge that samples the real start).
    task automatic do_div(input string tag, input logic [15:0] dd, input logic [7:0] ds,
                          input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                          input logic eo, input logic ez, input int poke);
        int  lat;
        logic busy_ok;
        @(negedge clk);
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 16'($urandom_range(0, 65535));
        divisor  = 8'($urandom_range(0, 255));
        lat      = 1;
        busy_ok  = 1'b1;
        while (done !== 1'b1 && lat < 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (lat == poke) begin
                start    = 1'b1;
                dividend = 16'h0010;
                divisor  = 8'h03;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".busy_during"}, busy_ok, 1'b1);
        chk({tag, ".busy_at_done"}, busy, 1'b0);
        chk({tag, ".quotient"}, quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".overflow"}, overflow, eo);
        chk({tag, ".div_by_zero"}, div_by_zero, ez);
        if (poke == exp_lat) begin
            start    = 1'b1;
            dividend = 16'h0010;
            divisor  = 8'h03;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".done_pulse_end"}, done, 1'b0);
        chk({tag, ".idle_after"}, busy, 1'b0);
        chk({tag, ".quotient_held"}, quotient, eq);
    endtask

    // Directed sequence
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.quotient", quotient, 8'h00);
        chk("reset.remainder", remainder, 8'h00);
        chk("reset.flags", {overflow, div_by_zero}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        do_div("basic_100_7",   16'd100,  8'd7,  11, 8'h0E, 8'h02, 1'b0, 1'b0, 0);
        do_div("div_zero",      16'h1234, 8'd0,  2,  8'h00, 8'h00, 1'b0, 1'b1, 0);
        do_div("ovf_check",     16'h4000, 8'd2,  2,  8'h00, 8'h00, 1'b1, 1'b0, 0);
        do_div("ignored_start", 16'd100,  8'd7,  11, 8'h0E, 8'h02, 1'b0, 1'b0, 5);
        do_div("start_in_done", 16'h00FF, 8'h10, 11, 8'h0F, 8'h0F, 1'b0, 1'b0, 11);
        do_div("exact_1000_10", 16'h03E8, 8'h0A, 11, 8'h64, 8'h00, 1'b0, 1'b0, 0);
`ifdef DIV_SIGNED_EN
        do_div("neg_dd",        16'hFF9C, 8'h07, 11, 8'hF2, 8'hFE, 1'b0, 1'b0, 0);
        do_div("neg_ds",        16'h0064, 8'hF9, 11, 8'hF2, 8'h02, 1'b0, 1'b0, 0);
        do_div("neg_both",      16'hFF9C, 8'hF9, 11, 8'h0E, 8'hFE, 1'b0, 1'b0, 0);
        do_div("q_min",         16'hFF00, 8'h02, 11, 8'h80, 8'h00, 1'b0, 1'b0, 0);
        do_div("ovf_fix_pos",   16'h0100, 8'h02, 11, 8'h00, 8'h00, 1'b1, 1'b0, 0);
        do_div("ovf_fix_m1",    16'hFF80, 8'hFF, 11, 8'h00, 8'h00, 1'b1, 1'b0, 0);
        do_div("ovf_fix_neg",   16'h7FFF, 8'h80, 11, 8'h00, 8'h00, 1'b1, 1'b0, 0);
        do_div("ovf_min_dd",    16'h8000, 8'h80, 2,  8'h00, 8'h00, 1'b1, 1'b0, 0);
`else
        do_div("u_big",         16'hC79C, 8'hC8, 11, 8'hFF, 8'h64, 1'b0, 1'b0, 0);
        do_div("u_ovf_ff9c",    16'hFF9C, 8'hC8, 2,  8'h00, 8'h00, 1'b1, 1'b0, 0);
        do_div("u_256_2",       16'h0100, 8'h02, 11, 8'h80, 8'h00, 1'b0, 1'b0, 0);
        do_div("u_ovf_ff00",    16'hFF00, 8'h02, 2,  8'h00, 8'h00, 1'b1, 1'b0, 0);
        do_div("u_ovf_equal",   16'h8000, 8'h80, 2,  8'h00, 8'h00, 1'b1, 1'b0, 0);
        do_div("u_max_q",       16'h7FFF, 8'h80, 11, 8'hFF, 8'h7F, 1'b0, 1'b0, 0);
`endif

        // Reset in the middle of CALC abandons the division.
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset.busy", busy, 1'b0);
        chk("midreset.done", done, 1'b0);
        chk("midreset.quotient", quotient, 8'h00);
        chk("midreset.remainder", remainder, 8'h00);
        chk("midreset.flags", {overflow, div_by_zero}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("midreset.no_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            chk("midreset.stays_idle", {busy, done}, 2'b00);
        end

        do_div("after_reset",   16'd100,  8'd7,  11, 8'h0E, 8'h02, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
